// File: rtl/updown_sweep_pkg.sv
// Shared definitions for the up/down triangle-sweep sequencer.
// Holds the state encoding and the default bus widths.
package updown_sweep_pkg;

    localparam int WIDTH_DEF = 5;
    localparam int CNT_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/updown_core.sv
// Up/down counter datapath. It owns the count register; the controller
// decides when to load it and when to step it.
module updown_core #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? (count_q + WIDTH'(1)) : (count_q - WIDTH'(1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep sequencer: steps the counter lo->hi->lo for a programmed
// number of sweeps (0 = endless) and reports busy/done/err.
module updown_sweep_ctrl
    import updown_sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] hi,
    input  logic [CNT_W-1:0] cycles,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [CNT_W-1:0] sweep_q, sweep_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             core_load;
    logic [WIDTH-1:0] core_load_val;
    logic             core_en;
    logic             core_up;
    logic [CNT_W-1:0] sweep_inc;

    // Wraps naturally at 2^CNT_W, which is what endless mode relies on.
    assign sweep_inc = sweep_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        lo_d          = lo_q;
        hi_d          = hi_q;
        cycles_d      = cycles_q;
        sweep_d       = sweep_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        core_load     = 1'b0;
        core_load_val = lo_q;
        core_en       = 1'b0;
        core_up       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (lo < hi) begin
                        lo_d          = lo;
                        hi_d          = hi;
                        cycles_d      = cycles;
                        sweep_d       = '0;
                        core_load     = 1'b1;
                        core_load_val = lo;
                        state_d       = ST_UP;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_UP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (count != hi_q) begin
                    core_en = 1'b1;
                    core_up = 1'b1;
                end else begin
                    core_en = 1'b1;
                    state_d = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (count != lo_q) begin
                    core_en = 1'b1;
                end else begin
                    sweep_d = sweep_inc;
                    // Final sweep parks the counter on lo for the done cycle.
                    if ((cycles_q != '0) && (sweep_inc == cycles_q)) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        core_en = 1'b1;
                        core_up = 1'b1;
                        state_d = ST_UP;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            cycles_q <= '0;
            sweep_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            cycles_q <= cycles_d;
            sweep_q  <= sweep_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    updown_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (core_load),
        .load_val (core_load_val),
        .en       (core_en),
        .up       (core_up),
        .count    (count)
    );

    assign dir  = (state_q == ST_UP);
    assign busy = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Self-checking bench for updown_sweep_ctrl: directed and randomized sweeps
// compared against a trajectory model built from the sweep rules.
module tb_updown_sweep_ctrl;

    localparam int W  = 5;
    localparam int CW = 4;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic [W-1:0]  lo      = '0;
    logic [W-1:0]  hi      = '0;
    logic [CW-1:0] cycles  = '0;
    logic [W-1:0]  count;
    logic          dir;
    logic          busy;
    logic          done;
    logic          err;

    int checks     = 0;
    int failures   = 0;
    int idle_count = 0;

    typedef struct {
        int c;
        int d;
    } step_t;
    step_t exp_q[$];

    updown_sweep_ctrl #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .stop    (stop),
        .lo      (lo),
        .hi      (hi),
        .cycles  (cycles),
        .count   (count),
        .dir     (dir),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected (count, dir) for every busy cycle: first leg starts at lo,
    // later legs restart at lo+1 because lo was already visited.
    task automatic build(input int l, input int h, input int cy, input int maxlen);
        int c;
        int sw;
        exp_q.delete();
        c  = l;
        sw = 0;
        while (1) begin
            for (int v = c; v <= h; v++) exp_q.push_back('{v, 1});
            for (int v = h - 1; v >= l; v--) exp_q.push_back('{v, 0});
            sw++;
            if (cy != 0 && sw == cy) break;
            if (exp_q.size() >= maxlen) break;
            c = l + 1;
        end
    endtask

    task automatic scramble();
        lo     = W'($urandom_range(31, 0));
        hi     = W'($urandom_range(31, 0));
        cycles = CW'($urandom_range(15, 0));
    endtask

    task automatic run_sweep(input int l, input int h, input int cy, input int stop_at, input bit noise);
        int n;
        build(l, h, cy, (cy == 0) ? stop_at + 1 : 100000);
        n      = exp_q.size();
        lo     = W'(l);
        hi     = W'(h);
        cycles = CW'(cy);
        start  = 1'b1;
        stop   = noise;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("busy_count", count, exp_q[i].c);
            chk("busy_dir", dir, exp_q[i].d);
            chk("busy_busy", busy, 1);
            chk("busy_done", done, 0);
            chk("busy_err", err, 0);
            if (noise) begin
                scramble();
                start = $urandom_range(1, 0) == 1;
            end
            if (i == stop_at) begin
                stop  = 1'b1;
                start = noise;
                tick();
                stop  = 1'b0;
                start = 1'b0;
                chk("stop_busy", busy, 0);
                chk("stop_count", count, exp_q[i].c);
                chk("stop_done", done, 0);
                chk("stop_dir", dir, 0);
                idle_count = exp_q[i].c;
                tick();
                chk("stop_hold", count, exp_q[i].c);
                chk("stop_idle", busy, 0);
                return;
            end
            tick();
            start = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_count", count, l);
        chk("done_dir", dir, 0);
        chk("done_err", err, 0);
        if (noise) scramble();
        start = noise;
        tick();
        start = 1'b0;
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_count", count, l);
        chk("post_err", err, 0);
        idle_count = l;
    endtask

    task automatic run_reject(input int l, input int h);
        lo     = W'(l);
        hi     = W'(h);
        cycles = CW'($urandom_range(15, 0));
        start  = 1'b1;
        tick();
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_count", count, idle_count);
        chk("rej_done", done, 0);
        tick();
        chk("rej_err_clr", err, 0);
        chk("rej_busy2", busy, 0);
        chk("rej_count2", count, idle_count);
    endtask

    initial begin
        int l;
        int h;
        int cy;
        int sa;
        bit nz;

        // Reset state
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dir", dir, 0);
        reset_n = 1'b1;
        tick();
        chk("rst_idle", busy, 0);

        // Asynchronous reset in the middle of an up leg
        lo     = W'(2);
        hi     = W'(9);
        cycles = CW'(1);
        start  = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_count", count, 4);
        chk("pre_rst_busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_count", count, 0);
        chk("async_busy", busy, 0);
        chk("async_done", done, 0);
        chk("async_dir", dir, 0);
        #3;
        reset_n = 1'b1;
        tick();
        chk("after_rst_busy", busy, 0);
        chk("after_rst_count", count, 0);
        idle_count = 0;

        run_sweep(2, 5, 1, -1, 1'b0);
        run_reject(5, 5);
        run_reject(7, 3);
        run_sweep(0, 31, 2, -1, 1'b0);
        run_sweep(1, 3, 0, 9, 1'b0);
        run_sweep(4, 6, 1, -1, 1'b0);
        // Endless mode long enough for the sweep counter to wrap
        run_sweep(1, 2, 0, 50, 1'b0);
        run_sweep(3, 8, 2, -1, 1'b1);
        run_sweep(10, 20, 1, 4, 1'b1);

        for (int k = 0; k < 16; k++) begin
            l = $urandom_range(31, 0);
            h = $urandom_range(31, 0);
            if (l < h) begin
                cy = $urandom_range(3, 0);
                nz = $urandom_range(1, 0) == 1;
                if (cy == 0) sa = $urandom_range(6 * (h - l), 0);
                else if ($urandom_range(1, 0) == 1) sa = $urandom_range(2 * (h - l), 0);
                else sa = -1;
                run_sweep(l, h, cy, sa, nz);
            end else begin
                run_reject(l, h);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
